std_sdivmod_pipe: RTL and testbench
===================================

Name: std_sdivmod_pipe

Overview:
- Multi-cycle signed integer divider that produces quotient and remainder together from one operation.
- Quotient truncates toward zero; remainder takes the sign of the dividend.
- Shared by the signed division and signed modulo primitives wherever a sequential divider is selected; sits behind the standard go/done control interface.
- Generalises the single-output pipes:
  - correct handling of negative operands,
  - defined divide-by-zero and overflow results,
  - zero-dividend early exit.

Parameters:
- width, 32, operand and result bit width (must be ≥ 2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- go  input  1  start request; must be held high until done.
- left  input  width  signed dividend; sampled at start only.
- right  input  width  signed divisor; sampled at start only.
- out_quotient  output  width  signed quotient, registered.
- out_remainder  output  width  signed remainder, registered.
- done  output  1  one-cycle pulse; results valid.

Behaviour:
- Reset values: out_quotient=0, out_remainder=0, done=0, state=IDLE. Reset takes priority over everything, including mid-operation: abort, no done.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start = go in IDLE.
  - On start, latch |left| and |right| as width-bit unsigned magnitudes (|-2^(width-1)| = 2^(width-1) fits), sign_q = left[msb]^right[msb], sign_r = left[msb].
  - Clear partial remainder and quotient; iteration counter = width-1.
- Early-exit classes, decided in IDLE from the raw inputs:
  - right==0 → FIX with q = all ones, r = left.
  - left==0 and right!=0 → FIX with q=0, r=0.
  - Otherwise → CALC.
- CALC: one restoring radix-2 step per cycle, MSB first.
  - Shift next dividend bit into the partial remainder (width+1 bits).
  - If partial remainder ≥ |right|: subtract and set the quotient bit to 1; else set it to 0.
  - After width steps (counter hits 0) → FIX.
- FIX: apply signs and register outputs.
  - q = sign_q ? -q_mag : q_mag, r = sign_r ? -r_mag : r_mag, both modulo 2^width.
  - Divide-by-zero values bypass sign fixing.
  - Overflow -2^(width-1) / -1 yields q = -2^(width-1) (wrap), r = 0, with no special case.
- DONE: done=1 for exactly one cycle, then → IDLE.
  - If go is still high in that IDLE cycle, a new operation starts. Control normally drops go the cycle after done.
- Latency (go first sampled in cycle 0):
  - normal: done in cycle width+2;
  - early exit: done in cycle 2.
- Outputs: change only in FIX and hold between operations.
- go low in CALC or FIX: abort to IDLE next edge; outputs keep previous values; done stays 0.
- Operand changes after the start cycle have no effect.
- done is never asserted in two consecutive cycles.

Optional Feature:
- Macro: SDIVMOD_DIV0_FLAG_EN.
- Defined:
  - Extra output port div_by_zero (1 bit, reset 0).
  - Registered in FIX as (latched right==0); valid with done and held until the next FIX.
  - Cleared on reset.
- Undefined: port absent; divide-by-zero results as above, with no indication.

Test Plan:
- width=32, left=100, right=7, go held → done at cycle 34, q=14, r=2; then go low → done=0, outputs hold.
- width=8: left=-7, right=2 → q=-3 (0xFD), r=-1 (0xFF). left=7, right=-2 → q=-3, r=1. left=-7, right=-2 → q=3, r=-1. Each done at cycle 10.
- width=8, left=-128, right=-1 → q=-128 (0x80), r=0. left=-128, right=1 → q=-128, r=0.
- width=8, right=0 with left=5 → q=0xFF, r=5, done at cycle 2. With left=0, right=3 → q=0, r=0, done at cycle 2. With SDIVMOD_DIV0_FLAG_EN: div_by_zero=1 for the first case, 0 for the second.
- width=16:
  - start 1000/3, assert reset at cycle 5 → next cycle done=0, outputs 0.
  - Restart with 1000/3 → done at cycle 18, q=333, r=1.
- width=16: start 50/5, drop go at cycle 4, raise go at cycle 6 with 9/4 → no done for the first operation; done at cycle 24, q=2, r=1.

Source files
------------

// File: rtl/std_sdivmod_pipe.sv
// Multi-cycle signed divider: quotient (truncated toward zero) and remainder (sign of dividend)
// from one restoring radix-2 pass. Define SDIVMOD_DIV0_FLAG_EN to add the div_by_zero output.
module std_sdivmod_pipe #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out_quotient,
    output logic [width-1:0] out_remainder,
    output logic             done
`ifdef SDIVMOD_DIV0_FLAG_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int CW = (width > 2) ? $clog2(width) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_next;
    logic [width-1:0] dvd, dsr, quo, rem;
    logic [CW-1:0]    cnt;
    logic             sign_q, sign_r, div0;

    logic [width-1:0] left_mag, right_mag;
    logic [width:0]   rem_shift, rem_diff;
    logic             ge;

    // Magnitude of -2^(width-1) wraps to 2^(width-1), which is exactly right as unsigned.
    assign left_mag  = left[width-1]  ? -left  : left;
    assign right_mag = right[width-1] ? -right : right;

    // Partial remainder stays below |right| <= 2^(width-1), so the borrow bit of the
    // width+1-bit difference is a reliable "less than" indicator.
    assign rem_shift = {rem, dvd[width-1]};
    assign rem_diff  = rem_shift - {1'b0, dsr};
    assign ge        = ~rem_diff[width];

    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (go) state_next = (right == '0 || left == '0) ? FIX : CALC;
            CALC: if (!go) state_next = IDLE;
                  else if (cnt == '0) state_next = FIX;
            FIX:  state_next = go ? DONE : IDLE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: only state and visible outputs are reset; the working registers are always
    // reloaded at start before they are read, so resetting them would buy nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_quotient  <= '0;
            out_remainder <= '0;
`ifdef SDIVMOD_DIV0_FLAG_EN
            div_by_zero   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (go) begin
                    dvd    <= left_mag;
                    dsr    <= right_mag;
                    sign_q <= left[width-1] ^ right[width-1];
                    sign_r <= left[width-1];
                    cnt    <= CW'(width - 1);
                    div0   <= (right == '0);
                    if (right == '0) begin
                        quo <= '1;
                        rem <= left;
                    end else begin
                        quo <= '0;
                        rem <= '0;
                    end
                end
                CALC: begin
                    rem <= ge ? rem_diff[width-1:0] : rem_shift[width-1:0];
                    quo <= {quo[width-2:0], ge};
                    dvd <= {dvd[width-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                end
                FIX: if (go) begin
                    if (div0) begin
                        out_quotient  <= quo;
                        out_remainder <= rem;
                    end else begin
                        out_quotient  <= sign_q ? -quo : quo;
                        out_remainder <= sign_r ? -rem : rem;
                    end
`ifdef SDIVMOD_DIV0_FLAG_EN
                    div_by_zero <= div0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_std_sdivmod_pipe.sv
// Scoreboard bench for std_sdivmod_pipe at widths 8, 16 and 32; expected values come from a
// longint reference model. Honours SDIVMOD_DIV0_FLAG_EN when defined.
module tb_std_sdivmod_pipe;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        go_a, go_b, go_c;
    logic [7:0]  left_a, right_a, q_a, r_a;
    logic [15:0] left_b, right_b, q_b, r_b;
    logic [31:0] left_c, right_c, q_c, r_c;
    logic        done_a, done_b, done_c;
    logic        dz_a, dz_b, dz_c;

    std_sdivmod_pipe #(.width(8)) dut_a (
        .clk(clk), .reset(reset), .go(go_a), .left(left_a), .right(right_a),
        .out_quotient(q_a), .out_remainder(r_a), .done(done_a)
`ifdef SDIVMOD_DIV0_FLAG_EN
        , .div_by_zero(dz_a)
`endif
    );
    std_sdivmod_pipe #(.width(16)) dut_b (
        .clk(clk), .reset(reset), .go(go_b), .left(left_b), .right(right_b),
        .out_quotient(q_b), .out_remainder(r_b), .done(done_b)
`ifdef SDIVMOD_DIV0_FLAG_EN
        , .div_by_zero(dz_b)
`endif
    );
    std_sdivmod_pipe #(.width(32)) dut_c (
        .clk(clk), .reset(reset), .go(go_c), .left(left_c), .right(right_c),
        .out_quotient(q_c), .out_remainder(r_c), .done(done_c)
`ifdef SDIVMOD_DIV0_FLAG_EN
        , .div_by_zero(dz_c)
`endif
    );

`ifndef SDIVMOD_DIV0_FLAG_EN
    assign dz_a = 1'b0;
    assign dz_b = 1'b0;
    assign dz_c = 1'b0;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int wid(int inst);
        return (inst == 0) ? 8 : (inst == 1) ? 16 : 32;
    endfunction

    // Reference: signed longint division truncates toward zero, % follows the dividend sign.
    function automatic exp_t model(int w, logic [31:0] l, logic [31:0] r);
        exp_t              e;
        logic [63:0]       mask;
        logic signed [31:0] ls, rs;
        longint            a, b;
        mask = (64'd1 << w) - 64'd1;
        ls   = $signed(l << (32 - w)) >>> (32 - w);
        rs   = $signed(r << (32 - w)) >>> (32 - w);
        a    = longint'(ls);
        b    = longint'(rs);
        if (b == 0) begin
            e.q   = mask[31:0];
            e.r   = l & mask[31:0];
            e.lat = 2;
            e.dz  = 1'b1;
        end else begin
            e.q   = 32'(a / b) & mask[31:0];
            e.r   = 32'(a % b) & mask[31:0];
            e.lat = (a == 0) ? 2 : w + 2;
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    task automatic set_in(int inst, logic g, logic [31:0] l, logic [31:0] r);
        case (inst)
            0: begin go_a = g; left_a = l[7:0];  right_a = r[7:0];  end
            1: begin go_b = g; left_b = l[15:0]; right_b = r[15:0]; end
            default: begin go_c = g; left_c = l; right_c = r; end
        endcase
    endtask

    function automatic logic get_done(int inst);
        return (inst == 0) ? done_a : (inst == 1) ? done_b : done_c;
    endfunction
    function automatic logic [31:0] get_q(int inst);
        return (inst == 0) ? 32'(q_a) : (inst == 1) ? 32'(q_b) : q_c;
    endfunction
    function automatic logic [31:0] get_r(int inst);
        return (inst == 0) ? 32'(r_a) : (inst == 1) ? 32'(r_b) : r_c;
    endfunction
    function automatic logic get_dz(int inst);
        return (inst == 0) ? dz_a : (inst == 1) ? dz_b : dz_c;
    endfunction

    // Drive one operation with go held, scramble operands after the start cycle, wait for
    // done, compare against the scoreboard, then drop go and check the outputs hold.
    task automatic run_op(int inst, logic [31:0] l, logic [31:0] r);
        exp_t e;
        int   start;
        sb.push_back(model(wid(inst), l, r));
        @(negedge clk);
        set_in(inst, 1'b1, l, r);
        start = cyc;
        @(negedge clk);
        set_in(inst, 1'b1, $urandom, $urandom);
        while (!get_done(inst) && (cyc - start) < 200) @(negedge clk);
        e = sb.pop_front();
        if (!get_done(inst)) begin
            check("done_timeout", 32'(get_done(inst)), 32'd1);
        end else begin
            check("latency", 32'(cyc - start), 32'(e.lat));
            check("quotient", get_q(inst), e.q);
            check("remainder", get_r(inst), e.r);
`ifdef SDIVMOD_DIV0_FLAG_EN
            check("div_by_zero", 32'(get_dz(inst)), 32'(e.dz));
`endif
        end
        set_in(inst, 1'b0, $urandom, $urandom);
        @(negedge clk);
        check("done_pulse_once", 32'(get_done(inst)), 32'd0);
        check("hold_quotient", get_q(inst), e.q);
        check("hold_remainder", get_r(inst), e.r);
    endtask

    initial begin
        exp_t e;
        int   start;
        logic seen;
        set_in(0, 1'b0, 0, 0);
        set_in(1, 1'b0, 0, 0);
        set_in(2, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_q", get_q(i), 32'd0);
            check("reset_r", get_r(i), 32'd0);
            check("reset_done", 32'(get_done(i)), 32'd0);
            check("reset_dz", 32'(get_dz(i)), 32'd0);
        end
        reset = 1'b0;

        run_op(2, 32'd100, 32'd7);

        run_op(0, -32'sd7, 32'd2);
        run_op(0, 32'd7, -32'sd2);
        run_op(0, -32'sd7, -32'sd2);
        run_op(0, 32'h80, 32'hFF);
        run_op(0, 32'h80, 32'd1);
        run_op(0, 32'd5, 32'd0);
        run_op(0, 32'd0, 32'd3);
        run_op(0, 32'd0, 32'd0);
        for (int i = 0; i < 12; i++) run_op(0, $urandom, $urandom_range(0, 255));
        for (int i = 0; i < 4; i++)  run_op(1, $urandom, $urandom_range(1, 70));
        run_op(2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2, $urandom, $urandom);

        // Reset mid-operation: no done, outputs cleared.
        @(negedge clk);
        set_in(1, 1'b1, 32'd1000, 32'd3);
        start = cyc;
        seen  = 1'b0;
        while ((cyc - start) < 5) begin
            @(negedge clk);
            if (done_b) seen = 1'b1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_done", 32'(done_b), 32'd0);
        check("reset_mid_q", 32'(q_b), 32'd0);
        check("reset_mid_r", 32'(r_b), 32'd0);
        check("reset_mid_no_early_done", 32'(seen), 32'd0);
        reset = 1'b0;
        set_in(1, 1'b0, 0, 0);
        run_op(1, 32'd1000, 32'd3);

        // Abort by dropping go in CALC, then restart with new operands.
        @(negedge clk);
        set_in(1, 1'b1, 32'd50, 32'd5);
        start = cyc;
        seen  = 1'b0;
        while ((cyc - start) < 24) begin
            if (done_b) seen = 1'b1;
            if ((cyc - start) == 4) set_in(1, 1'b0, 32'd50, 32'd5);
            if ((cyc - start) == 5) begin
                check("abort_hold_q", 32'(q_b), 32'd333);
                check("abort_hold_r", 32'(r_b), 32'd1);
            end
            if ((cyc - start) == 6) begin
                set_in(1, 1'b1, 32'd9, 32'd4);
                sb.push_back(model(16, 32'd9, 32'd4));
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        check("abort_no_done", 32'(seen), 32'd0);
        check("restart_done", 32'(done_b), 32'd1);
        check("restart_latency", 32'(cyc - start - 6), 32'(e.lat));
        check("restart_q", 32'(q_b), e.q);
        check("restart_r", 32'(r_b), e.r);
        set_in(1, 1'b0, 0, 0);
        @(negedge clk);
        check("restart_done_drop", 32'(done_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
